mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
MIPS memory-access stage plus MEM/WB pipeline register. Consumes the EX/MEM register outputs (ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM) and drives a req/ack data-memory port with byte/halfword/word sizing. Stalls the pipeline until the memory acknowledges, with a bounded timeout. Aligns load data and registers the results for writeback.

Parameters:
TIMEOUT, 16, max cycles a request waits for dmem_ack before abort (>=1)
CNT_W, 5, width of wait counter (must hold TIMEOUT)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high
RegWriteM  in  1  instruction writes register file
MemtoRegM  in  1  instruction is a load
MemWriteM  in  1  instruction is a store
MemSizeM  in  2  00 word, 01 half, 10 byte, 11 treated as word
MemSignedM  in  1  sign-extend sub-word loads
ALUOutM  in  32  effective address / ALU result
WriteDataM  in  32  store data (right-justified)
WriteRegM  in  5  destination register
dmem_req  out  1  request valid
dmem_we  out  1  1 = store
dmem_addr  out  32  {ALUOutM[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables, be[3] = byte offset 0 (big-endian)
dmem_rdata  in  32  read data, valid with ack
dmem_ack  in  1  completes the current request this cycle
StallM  out  1  freeze PC/IF/ID/EX/EX-MEM registers
RegWriteW  out  1  registered
MemtoRegW  out  1  registered
ReadDataW  out  32  aligned, extended load data
ALUOutW  out  32  registered ALUOutM
WriteRegW  out  5  registered
AlignErrW  out  1  misaligned access flagged
BusErrW  out  1  request timed out

Behaviour:
- memop = MemtoRegM | MemWriteM; loads take priority if both set (dmem_we=0).
- aligned: word needs ALUOutM[1:0]=00, half needs ALUOutM[0]=0, byte always.
- States IDLE, WAIT; cnt counts unacked request cycles.
- IDLE: memop & aligned -> dmem_req=1. ack same cycle -> stay IDLE, no stall. No ack -> WAIT, cnt=1, StallM=1.
- WAIT: dmem_req=1, StallM=1 while no ack. cnt increments each cycle. ack -> StallM=0, -> IDLE, cnt=0.
- Abort: in WAIT with cnt==TIMEOUT and no ack -> dmem_req=0, StallM=0, abort=1, -> IDLE, cnt=0. Max stall is TIMEOUT cycles.
- Each ack retires exactly one request. A request still high in the cycle after an ack is a new request (back-to-back memory ops).
- Misaligned memop: no request, no stall.
- Store lanes:
  - byte: wdata = {4{WriteDataM[7:0]}}, be = 1000>>off.
  - half: wdata = {2{WriteDataM[15:0]}}, be = 1100 (off 0) or 0011 (off 2).
  - word: be = 1111.
- Load extract (big-endian):
  - byte off k -> rdata[31-8k -: 8].
  - half off 0 -> [31:16]; off 2 -> [15:0].
  - zero- or sign-extend per MemSignedM.
- MEM/WB register, each rising edge:
  - If StallM=1: load bubble (RegWriteW=0, MemtoRegW=0, AlignErrW=0, BusErrW=0; data fields don't-care, hold).
  - Else: load M fields, ReadDataW = aligned ack data.
  - On misalign: AlignErrW=1, RegWriteW=0, MemtoRegW=0.
  - On abort: BusErrW=1, RegWriteW=0, MemtoRegW=0.
- Non-memory instruction: passes in 1 cycle; dmem_req=0, ReadDataW=0.
- Reset (async, any time incl. mid-WAIT):
  - state=IDLE, cnt=0.
  - All W outputs = 0.
  - dmem_req=0, StallM=0 while reset is high.
  - No request is replayed after reset.

Test Plan:
- Zero-wait load word: ALUOutM=0x100, MemtoRegM=1, RegWriteM=1, ack same cycle, rdata=0xDEADBEEF -> StallM never 1; next edge ReadDataW=0xDEADBEEF, RegWriteW=1, WriteRegW matches.
- Signed byte load, 3-cycle ack: ALUOutM=0x103, MemSizeM=10, MemSignedM=1, rdata=0x000000F0 on ack in 3rd request cycle -> StallM=1 for 2 cycles with bubbles in WB; then ReadDataW=0xFFFFFFF0, dmem_addr=0x100.
- Half store: ALUOutM=0x202, MemSizeM=01, WriteDataM=0x1234ABCD, MemWriteM=1 -> dmem_we=1, be=0011, wdata=0xABCDABCD, RegWriteW=0.
- Misaligned word load at 0x101 -> dmem_req=0, StallM=0, next edge AlignErrW=1, RegWriteW=0.
- Timeout, TIMEOUT=4, ack held 0 -> StallM=1 for 4 cycles; 5th cycle req=0, StallM=0; next edge BusErrW=1, RegWriteW=0; FSM back in IDLE.
- Back-to-back loads plus reset in WAIT:
  - Two consecutive zero-wait loads -> two acks, two WB results, no stall.
  - Reset asserted in WAIT -> req/StallM drop immediately, W outputs 0.
  - After release with a non-memory instruction -> dmem_req stays 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MIPS memory-access stage followed by the MEM/WB pipeline register.
//   Drives a req/ack data-memory port with byte/halfword/word sizing,
//   stalls the upstream pipeline until the memory acknowledges (bounded
//   by TIMEOUT), aligns/extends load data and registers results for WB.
//
//   State table:
//     state | meaning
//     IDLE  | no request outstanding; a new aligned memop is issued here
//     WAIT  | request issued, waiting for dmem_ack; cnt = unacked cycles
//
// Ports:
//   clk, reset                 pipeline clock, async active-high reset
//   RegWriteM..WriteRegM       EX/MEM register outputs
//   dmem_*                     data-memory request/ack port (big-endian lanes)
//   StallM                     freezes PC/IF/ID/EX/EX-MEM registers
//   RegWriteW..BusErrW         MEM/WB register outputs
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignedM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    output logic        AlignErrW,
    output logic        BusErrW
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state, stateNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic               memOp, isAligned, misAlign, abort;
    logic [1:0]         byteOff;
    logic [7:0]         byteSel;
    logic [15:0]        halfSel;
    logic [31:0]        loadData;

    always_comb begin
        memOp    = MemtoRegM | MemWriteM;
        byteOff  = ALUOutM[1:0];
        case (MemSizeM)
            2'b01:   isAligned = ~ALUOutM[0];
            2'b10:   isAligned = 1'b1;
            default: isAligned = (ALUOutM[1:0] == 2'b00);
        endcase
        misAlign = memOp & ~isAligned;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Request/stall are gated by reset so nothing is presented to memory
    // while reset is held, even with a memop sitting on the M inputs.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        dmem_req  = 1'b0;
        StallM    = 1'b0;
        abort     = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (memOp && isAligned) begin
                        dmem_req = 1'b1;
                        if (!dmem_ack) begin
                            stateNext = WAIT;
                            cntNext   = CNT_W'(1);
                            StallM    = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        dmem_req  = 1'b1;
                        stateNext = IDLE;
                        cntNext   = '0;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        // Give up: drop the request and let the pipeline advance.
                        abort     = 1'b1;
                        stateNext = IDLE;
                        cntNext   = '0;
                    end else begin
                        dmem_req  = 1'b1;
                        StallM    = 1'b1;
                        cntNext   = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            endcase
        end
    end

    // Store lane steering; loads take priority when both flags are set.
    always_comb begin
        dmem_we   = MemWriteM & ~MemtoRegM;
        dmem_addr = {ALUOutM[31:2], 2'b00};
        case (MemSizeM)
            2'b10: begin
                dmem_wdata = {4{WriteDataM[7:0]}};
                dmem_be    = 4'b1000 >> byteOff;
            end
            2'b01: begin
                dmem_wdata = {2{WriteDataM[15:0]}};
                dmem_be    = byteOff[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                dmem_wdata = WriteDataM;
                dmem_be    = 4'b1111;
            end
        endcase
    end

    // Big-endian extraction: byte offset 0 is the most significant lane.
    always_comb begin
        case (byteOff)
            2'd0:    byteSel = dmem_rdata[31:24];
            2'd1:    byteSel = dmem_rdata[23:16];
            2'd2:    byteSel = dmem_rdata[15:8];
            default: byteSel = dmem_rdata[7:0];
        endcase
        halfSel = byteOff[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
        case (MemSizeM)
            2'b10:   loadData = {{24{MemSignedM & byteSel[7]}}, byteSel};
            2'b01:   loadData = {{16{MemSignedM & halfSel[15]}}, halfSel};
            default: loadData = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
            WriteRegW <= '0;
            AlignErrW <= 1'b0;
            BusErrW   <= 1'b0;
        end else if (StallM) begin
            // Bubble into WB; data fields simply hold.
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            AlignErrW <= 1'b0;
            BusErrW   <= 1'b0;
        end else begin
            RegWriteW <= RegWriteM & ~misAlign & ~abort;
            MemtoRegW <= MemtoRegM & ~misAlign & ~abort;
            AlignErrW <= misAlign;
            BusErrW   <= abort;
            ALUOutW   <= ALUOutM;
            WriteRegW <= WriteRegM;
            ReadDataW <= (MemtoRegM && dmem_req && dmem_ack) ? loadData : 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemtoRegM, MemWriteM, MemSignedM;
    logic [1:0]  MemSizeM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        dmem_req, dmem_we, dmem_ack, StallM;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        RegWriteW, MemtoRegW, AlignErrW, BusErrW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0]  WriteRegW;

    int numChecks = 0;
    int numFails  = 0;

    mem_access_stage #(.TIMEOUT(4), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .MemSizeM(MemSizeM), .MemSignedM(MemSignedM), .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .StallM(StallM),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
        .ALUOutW(ALUOutW), .WriteRegW(WriteRegW), .AlignErrW(AlignErrW),
        .BusErrW(BusErrW)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setOp(input logic rw, input logic ld, input logic st,
                         input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd);
        RegWriteM  = rw;
        MemtoRegM  = ld;
        MemWriteM  = st;
        MemSizeM   = sz;
        MemSignedM = sgn;
        ALUOutM    = addr;
        WriteDataM = wd;
        WriteRegM  = rd;
    endtask

    initial begin
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        setOp(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 5'd1);
        #2;
        checkVal("rst_req",       dmem_req,  0);
        checkVal("rst_stall",     StallM,    0);
        checkVal("rst_regwrite",  RegWriteW, 0);
        checkVal("rst_readdata",  ReadDataW, 0);
        checkVal("rst_aluout",    ALUOutW,   0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Two back-to-back zero-wait word loads
        setOp(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 5'd5);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        checkVal("lw0_req",   dmem_req,  1);
        checkVal("lw0_stall", StallM,    0);
        checkVal("lw0_addr",  dmem_addr, 32'h100);
        checkVal("lw0_we",    dmem_we,   0);
        tick();
        checkVal("lw0_rdW",   ReadDataW, 32'hDEADBEEF);
        checkVal("lw0_rwW",   RegWriteW, 1);
        checkVal("lw0_m2rW",  MemtoRegW, 1);
        checkVal("lw0_wrW",   WriteRegW, 5);
        setOp(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h104, 32'h0, 5'd6);
        dmem_rdata = 32'h11223344;
        #1;
        checkVal("lw1_req",   dmem_req,  1);
        checkVal("lw1_stall", StallM,    0);
        tick();
        checkVal("lw1_rdW",   ReadDataW, 32'h11223344);
        checkVal("lw1_wrW",   WriteRegW, 6);
        checkVal("lw1_aluW",  ALUOutW,   32'h104);

        // Signed byte load at offset 3, acked in 3rd request cycle
        setOp(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 5'd7);
        dmem_ack = 1'b0; dmem_rdata = 32'h000000F0;
        #1;
        checkVal("lb_req_c1",   dmem_req,  1);
        checkVal("lb_stall_c1", StallM,    1);
        checkVal("lb_addr",     dmem_addr, 32'h100);
        checkVal("lb_be",       dmem_be,   4'b0001);
        tick();
        checkVal("lb_bubble1",  RegWriteW, 0);
        #1;
        checkVal("lb_stall_c2", StallM,    1);
        tick();
        checkVal("lb_bubble2",  RegWriteW, 0);
        dmem_ack = 1'b1;
        #1;
        checkVal("lb_stall_c3", StallM,    0);
        checkVal("lb_req_c3",   dmem_req,  1);
        tick();
        checkVal("lb_rdW",      ReadDataW, 32'hFFFFFFF0);
        checkVal("lb_rwW",      RegWriteW, 1);

        // Half store at offset 2
        setOp(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 5'd0);
        #1;
        checkVal("sh_we",    dmem_we,    1);
        checkVal("sh_be",    dmem_be,    4'b0011);
        checkVal("sh_wdata", dmem_wdata, 32'hABCDABCD);
        tick();
        checkVal("sh_rwW",   RegWriteW,  0);
        checkVal("sh_rdW",   ReadDataW,  0);

        // Byte store at offset 1
        setOp(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h301, 32'hAAAA0055, 5'd0);
        #1;
        checkVal("sb_be",    dmem_be,    4'b0100);
        checkVal("sb_wdata", dmem_wdata, 32'h55555555);
        tick();

        // Halfword loads at offset 0, unsigned then signed
        setOp(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h400, 32'h0, 5'd8);
        dmem_rdata = 32'h87654321;
        #1;
        checkVal("lhu_be", dmem_be, 4'b1100);
        tick();
        checkVal("lhu_rdW", ReadDataW, 32'h00008765);
        MemSignedM = 1'b1;
        tick();
        checkVal("lh_rdW", ReadDataW, 32'hFFFF8765);
        ALUOutM = 32'h402;
        tick();
        checkVal("lh2_rdW", ReadDataW, 32'h00004321);

        // Misaligned word load
        dmem_ack = 1'b0;
        setOp(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 5'd9);
        #1;
        checkVal("mis_req",   dmem_req,  0);
        checkVal("mis_stall", StallM,    0);
        tick();
        checkVal("mis_alignW", AlignErrW, 1);
        checkVal("mis_rwW",    RegWriteW, 0);
        checkVal("mis_m2rW",   MemtoRegW, 0);

        // Timeout with TIMEOUT=4
        setOp(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h500, 32'h0, 5'd10);
        for (int i = 1; i <= 4; i++) begin
            #1;
            checkVal($sformatf("to_stall_c%0d", i), StallM, 1);
            checkVal($sformatf("to_req_c%0d", i), dmem_req, 1);
            tick();
            checkVal($sformatf("to_bus_c%0d", i), BusErrW, 0);
        end
        #1;
        checkVal("to_req_c5",   dmem_req, 0);
        checkVal("to_stall_c5", StallM,   0);
        tick();
        checkVal("to_busW", BusErrW,   1);
        checkVal("to_rwW",  RegWriteW, 0);
        // Back in IDLE: a non-memory op must not raise a request
        setOp(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h555, 32'h0, 5'd11);
        #1;
        checkVal("to_idle_req", dmem_req, 0);
        tick();
        checkVal("alu_aluW", ALUOutW,   32'h555);
        checkVal("alu_rwW",  RegWriteW, 1);
        checkVal("alu_rdW",  ReadDataW, 0);
        checkVal("alu_busW", BusErrW,   0);

        // Reset asserted while in WAIT
        setOp(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h600, 32'h0, 5'd12);
        #1;
        checkVal("rw_stall_c1", StallM, 1);
        tick();
        checkVal("rw_stall_c2", StallM, 1);
        #2 reset = 1'b1;
        #1;
        checkVal("rw_req",   dmem_req,  0);
        checkVal("rw_stall", StallM,    0);
        checkVal("rw_aluW",  ALUOutW,   0);
        checkVal("rw_wrW",   WriteRegW, 0);
        setOp(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h77, 32'h0, 5'd13);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("rw_post_req",   dmem_req, 0);
        checkVal("rw_post_stall", StallM,   0);
        tick();
        checkVal("rw_post_req2",  dmem_req,  0);
        checkVal("rw_post_aluW",  ALUOutW,   32'h77);
        checkVal("rw_post_rwW",   RegWriteW, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
